window_fetch_3x3: RTL and testbench
===================================

WINDOW_FETCH_3X3 -- requirements
Module: window_fetch_3x3

Interface
REQ-001 Parameter DATA_WIDTH, default 8, sets the pixel width in bits.
REQ-002 Parameter MAX_IMAGE_SIZE, default 512, sets the maximum image width/height in pixels.
REQ-003 Parameter MAX_IMAGE_SIZE_LOG2, default 9; coordinate ports SHALL be MAX_IMAGE_SIZE_LOG2+1 bits wide (CW).
REQ-004 clk  in  1  single clock; all logic SHALL be on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  single-cycle request to begin a frame scan; sampled in IDLE only.
REQ-007 img_width  in  CW  image width W, latched on accepted start.
REQ-008 img_height  in  CW  image height H, latched on accepted start.
REQ-009 busy  out  1  high in any state other than IDLE.
REQ-010 done  out  1  one-cycle pulse at frame end.
REQ-011 mem_we  out  1  write enable to the padded pixel memory; SHALL be constant 0.
REQ-012 mem_cell_x, mem_cell_y  out  CW each  padded-memory read address.
REQ-013 mem_rdata  in  DATA_WIDTH  memory read data, valid exactly one cycle after address.
REQ-014 win_valid  out  1  window available; win_ready  in  1  consumer accepts.
REQ-015 win_data  out  9*DATA_WIDTH  3x3 window, tap k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-016 win_x, win_y  out  CW each  centre pixel coordinate (1-based); win_last  out  1  final window of frame.

Function
REQ-017 Image pixel (x,y), 1<=x<=W, 1<=y<=H, SHALL reside at memory cell (x,y).
REQ-018 Tap k = 3*(dy+1)+(dx+1), dy,dx in {-1,0,1}; tap 0 = top-left, tap 4 = centre, tap 8 = bottom-right.
REQ-019 Tap at (x+dx, y+dy) with coordinate 0, x+dx>W or y+dy>H SHALL be forced to 0, regardless of memory contents.
REQ-020 Scan order raster: x from 1 to W inner, y from 1 to H outer.
REQ-021 FSM states: IDLE, FETCH, PRESENT, DONE.
REQ-022 IDLE -> FETCH on start with 1<=W<=MAX_IMAGE_SIZE and 1<=H<=MAX_IMAGE_SIZE; centre set to (1,1).
REQ-023 IDLE -> DONE on start with W or H zero or above MAX_IMAGE_SIZE; no windows produced.
REQ-024 FETCH runs tap counter k=0..9: for k<=8 drive address of tap k; for k>=1 capture mem_rdata (or 0 if masked) into tap k-1; after k=9 -> PRESENT.
REQ-025 Masked taps SHALL still drive a clamped in-range address; their data SHALL be discarded.
REQ-026 PRESENT: win_valid=1; win_data, win_x, win_y and win_last held stable until win_valid&&win_ready.
REQ-027 On handshake: if last pixel -> DONE, else advance centre and -> FETCH next cycle.
REQ-028 win_last=1 only when centre = (W,H).
REQ-029 DONE lasts one cycle with done=1, then -> IDLE.
REQ-030 Latency: start sampled at edge t -> first win_valid high in cycle t+11; each subsequent window 10 cycles after the preceding handshake.
REQ-031 start while busy SHALL be ignored; img_width/img_height changes while busy SHALL have no effect.
REQ-032 mem_cell_x/mem_cell_y SHALL hold their last value outside FETCH.

Reset
REQ-033 rst=1 at any edge SHALL force IDLE, clear tap counter and centre, abandon any frame in progress.
REQ-034 Reset values: busy=0, done=0, win_valid=0, win_last=0, win_data=0, win_x=0, win_y=0, mem_cell_x=0, mem_cell_y=0, mem_we=0.
REQ-035 start asserted in the same cycle as rst SHALL be ignored.

Verification
REQ-036 W=H=1, cell(1,1)=0x55, all other cells 0xFF -> one window, tap4=0x55, other taps 0, win_last=1, done pulse one cycle after handshake.
REQ-037 W=H=3, pixels 1..9 raster -> 9 windows; (1,1) taps {0,0,0,0,1,2,0,4,5}; (2,2) taps {1..9}; (3,3) taps {5,6,0,8,9,0,0,0,0}.
REQ-038 win_ready low 5 cycles in PRESENT -> win_valid, win_data, win_x, win_y stable; no new memory addresses; scan resumes after handshake.
REQ-039 start with W=0, H=4 -> busy for one cycle, done pulse in cycle t+1, win_valid never asserted.
REQ-040 rst during FETCH of pixel (2,1) -> all outputs at reset values next cycle; new start restarts scan at (1,1).
REQ-041 start pulsed during PRESENT with different W -> ignored; frame completes with original W.

Source files
------------

// File: rtl/window_fetch_3x3.sv
// window_fetch_3x3
// Walks a W x H image in raster order. For every centre pixel it reads the
// nine cells of the surrounding 3x3 neighbourhood from a padded pixel memory.
// It then presents the window on a valid/ready output.
// Neighbours that fall outside the image are delivered as zero. Their reads
// are still issued, but to a clamped in-range address.
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   start                    frame request, honoured only while idle
//   img_width, img_height    frame size, latched when start is accepted
//   busy, done               activity flag and one-cycle end-of-frame pulse
//   mem_we                   memory write enable, tied low
//   mem_cell_x, mem_cell_y   padded-memory read address
//   mem_rdata                read data, one cycle after the address
//   win_valid, win_ready     window handshake
//   win_data                 nine taps, tap k at [k*DATA_WIDTH +: DATA_WIDTH]
//   win_x, win_y, win_last   1-based centre coordinate and final-window flag
module window_fetch_3x3 #(
  parameter int DATA_WIDTH          = 8,
  parameter int MAX_IMAGE_SIZE      = 512,
  parameter int MAX_IMAGE_SIZE_LOG2 = 9
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [MAX_IMAGE_SIZE_LOG2:0]   img_width,
  input  logic [MAX_IMAGE_SIZE_LOG2:0]   img_height,
  output logic                           busy,
  output logic                           done,
  output logic                           mem_we,
  output logic [MAX_IMAGE_SIZE_LOG2:0]   mem_cell_x,
  output logic [MAX_IMAGE_SIZE_LOG2:0]   mem_cell_y,
  input  logic [DATA_WIDTH-1:0]          mem_rdata,
  output logic                           win_valid,
  input  logic                           win_ready,
  output logic [9*DATA_WIDTH-1:0]        win_data,
  output logic [MAX_IMAGE_SIZE_LOG2:0]   win_x,
  output logic [MAX_IMAGE_SIZE_LOG2:0]   win_y,
  output logic                           win_last
);

  localparam int CW = MAX_IMAGE_SIZE_LOG2 + 1;
  localparam logic [CW-1:0] MAX_DIM = CW'(MAX_IMAGE_SIZE);
  localparam logic [CW-1:0] ONE     = CW'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, PRESENT = 2'd2, DONE = 2'd3} state_t;

  // Neighbour coordinate c + (d - 1), one bit wider so that W+1 is representable.
  function automatic logic [CW:0] offs(input logic [CW-1:0] c, input logic [1:0] d);
    return ({1'b0, c} + {{(CW-1){1'b0}}, d}) - {{CW{1'b0}}, 1'b1};
  endfunction

  // True when a neighbour coordinate lies in the zero padding ring.
  function automatic logic is_oob(input logic [CW:0] p, input logic [CW-1:0] lim);
    return (p == {(CW+1){1'b0}}) || (p > {1'b0, lim});
  endfunction

  // Pulls a padding coordinate back onto the nearest image row/column.
  function automatic logic [CW-1:0] clamp(input logic [CW:0] p, input logic [CW-1:0] lim);
    logic [CW-1:0] r;
    if (p == {(CW+1){1'b0}}) begin
      r = ONE;
    end else if (p > {1'b0, lim}) begin
      r = lim;
    end else begin
      r = p[CW-1:0];
    end
    return r;
  endfunction

  // Tap index to {dy index, dx index}, each index 0..2 meaning -1..+1.
  function automatic logic [3:0] tap_dxy(input logic [3:0] k);
    logic [3:0] r;
    case (k)
      4'd0:    r = {2'd0, 2'd0};
      4'd1:    r = {2'd0, 2'd1};
      4'd2:    r = {2'd0, 2'd2};
      4'd3:    r = {2'd1, 2'd0};
      4'd4:    r = {2'd1, 2'd1};
      4'd5:    r = {2'd1, 2'd2};
      4'd6:    r = {2'd2, 2'd0};
      4'd7:    r = {2'd2, 2'd1};
      4'd8:    r = {2'd2, 2'd2};
      default: r = {2'd1, 2'd1};
    endcase
    return r;
  endfunction

  state_t                  state_r, next_state_s;
  logic [3:0]              k_r;
  logic [CW-1:0]           w_r, h_r, cx_r, cy_r, mem_x_r, mem_y_r;
  logic [9*DATA_WIDTH-1:0] win_data_r;
  logic                    busy_r, done_r, win_valid_r, win_last_r;

  logic                    frame_ok_s, last_pix_s, hs_s, cap_mask_s;
  logic [CW-1:0]           adv_x_s, adv_y_s, iss_cx_s, iss_cy_s, iss_w_s, iss_h_s;
  logic [CW-1:0]           iss_addr_x_s, iss_addr_y_s;
  logic [3:0]              iss_k_s, iss_dxy_s, cap_k_s, cap_dxy_s;
  logic [DATA_WIDTH-1:0]   cap_data_s;

  // Address issue and data capture datapath. The next address to drive depends on
  // which centre the following fetch cycle belongs to: (1,1) on a new frame, the
  // advanced centre after a handshake, or the current centre mid-fetch.
  always_comb begin
    frame_ok_s = (img_width  != {CW{1'b0}}) && (img_width  <= MAX_DIM) &&
                 (img_height != {CW{1'b0}}) && (img_height <= MAX_DIM);
    hs_s       = (state_r == PRESENT) && win_valid_r && win_ready;
    last_pix_s = (cx_r == w_r) && (cy_r == h_r);
    if (cx_r == w_r) begin
      adv_x_s = ONE;
      adv_y_s = cy_r + ONE;
    end else begin
      adv_x_s = cx_r + ONE;
      adv_y_s = cy_r;
    end
    case (state_r)
      IDLE: begin
        iss_cx_s = ONE;     iss_cy_s = ONE;
        iss_w_s  = img_width; iss_h_s = img_height;
        iss_k_s  = 4'd0;
      end
      PRESENT: begin
        iss_cx_s = adv_x_s; iss_cy_s = adv_y_s;
        iss_w_s  = w_r;     iss_h_s  = h_r;
        iss_k_s  = 4'd0;
      end
      FETCH: begin
        iss_cx_s = cx_r;    iss_cy_s = cy_r;
        iss_w_s  = w_r;     iss_h_s  = h_r;
        iss_k_s  = k_r + 4'd1;
      end
      default: begin
        iss_cx_s = cx_r;    iss_cy_s = cy_r;
        iss_w_s  = w_r;     iss_h_s  = h_r;
        iss_k_s  = 4'd0;
      end
    endcase
    iss_dxy_s    = tap_dxy(iss_k_s);
    iss_addr_x_s = clamp(offs(iss_cx_s, iss_dxy_s[1:0]), iss_w_s);
    iss_addr_y_s = clamp(offs(iss_cy_s, iss_dxy_s[3:2]), iss_h_s);
    // Data returning now belongs to the tap addressed in the previous cycle.
    cap_k_s    = k_r - 4'd1;
    cap_dxy_s  = tap_dxy(cap_k_s);
    cap_mask_s = is_oob(offs(cx_r, cap_dxy_s[1:0]), w_r) ||
                 is_oob(offs(cy_r, cap_dxy_s[3:2]), h_r);
    if (cap_mask_s) begin
      cap_data_s = {DATA_WIDTH{1'b0}};
    end else begin
      cap_data_s = mem_rdata;
    end
  end

  // Next-state logic of the frame sequencer.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          next_state_s = frame_ok_s ? FETCH : DONE;
        end else begin
          next_state_s = IDLE;
        end
      end
      FETCH: begin
        if (k_r == 4'd9) begin
          next_state_s = PRESENT;
        end else begin
          next_state_s = FETCH;
        end
      end
      PRESENT: begin
        if (hs_s) begin
          next_state_s = last_pix_s ? DONE : FETCH;
        end else begin
          next_state_s = PRESENT;
        end
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Frame geometry, centre, tap counter, window and address registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      win_valid_r <= 1'b0;
      win_last_r  <= 1'b0;
      win_data_r  <= {(9*DATA_WIDTH){1'b0}};
      k_r         <= 4'd0;
      w_r         <= {CW{1'b0}};
      h_r         <= {CW{1'b0}};
      cx_r        <= {CW{1'b0}};
      cy_r        <= {CW{1'b0}};
      mem_x_r     <= {CW{1'b0}};
      mem_y_r     <= {CW{1'b0}};
    end else begin
      busy_r <= (next_state_s != IDLE);
      done_r <= (next_state_s == DONE);
      case (state_r)
        IDLE: begin
          if (start && frame_ok_s) begin
            w_r     <= img_width;
            h_r     <= img_height;
            cx_r    <= ONE;
            cy_r    <= ONE;
            k_r     <= 4'd0;
            mem_x_r <= iss_addr_x_s;
            mem_y_r <= iss_addr_y_s;
          end
        end
        FETCH: begin
          if (k_r != 4'd0) begin
            win_data_r[cap_k_s*DATA_WIDTH +: DATA_WIDTH] <= cap_data_s;
          end
          if (k_r < 4'd8) begin
            mem_x_r <= iss_addr_x_s;
            mem_y_r <= iss_addr_y_s;
          end
          if (k_r == 4'd9) begin
            k_r         <= 4'd0;
            win_valid_r <= 1'b1;
            win_last_r  <= last_pix_s;
          end else begin
            k_r <= k_r + 4'd1;
          end
        end
        PRESENT: begin
          if (hs_s) begin
            win_valid_r <= 1'b0;
            win_last_r  <= 1'b0;
            if (!last_pix_s) begin
              cx_r    <= adv_x_s;
              cy_r    <= adv_y_s;
              mem_x_r <= iss_addr_x_s;
              mem_y_r <= iss_addr_y_s;
            end
          end
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign mem_we     = 1'b0;
  assign mem_cell_x = mem_x_r;
  assign mem_cell_y = mem_y_r;
  assign win_valid  = win_valid_r;
  assign win_data   = win_data_r;
  assign win_x      = cx_r;
  assign win_y      = cy_r;
  assign win_last   = win_last_r;

endmodule

// File: tb/tb_window_fetch_3x3.sv
// Scoreboard bench for window_fetch_3x3: a neighbourhood model fills an
// expected-window queue per frame; a negedge monitor pops and compares on
// every handshake and checks hold-while-stalled and window spacing.
module tb_window_fetch_3x3;

  localparam int DW = 8;
  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          rst, start, busy, done, mem_we, win_valid, win_ready, win_last;
  logic [CW-1:0] img_width, img_height, mem_cell_x, mem_cell_y, win_x, win_y;
  logic [DW-1:0] mem_rdata;
  logic [9*DW-1:0] win_data;

  window_fetch_3x3 #(.DATA_WIDTH(DW), .MAX_IMAGE_SIZE(512), .MAX_IMAGE_SIZE_LOG2(9)) dut (
    .clk(clk), .rst(rst), .start(start), .img_width(img_width), .img_height(img_height),
    .busy(busy), .done(done), .mem_we(mem_we), .mem_cell_x(mem_cell_x), .mem_cell_y(mem_cell_y),
    .mem_rdata(mem_rdata), .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
    .win_x(win_x), .win_y(win_y), .win_last(win_last)
  );

  always #5 clk = ~clk;

  // Padded pixel memory, indexed [y][x], synchronous read.
  logic [DW-1:0] mem [0:15][0:15];
  always @(posedge clk) mem_rdata <= mem[mem_cell_y[3:0]][mem_cell_x[3:0]];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [9*DW-1:0] data;
    int              x;
    int              y;
    bit              last;
  } win_t;

  win_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   ready_mode = 0;   // 0 random, 1 always ready, 2 never ready

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: every pixel of the frame in raster order, neighbours outside the image read as zero.
  function automatic void push_frame(input int w, input int h);
    for (int y = 1; y <= h; y++) begin
      for (int x = 1; x <= w; x++) begin
        win_t e;
        e.data = '0;
        for (int dy = -1; dy <= 1; dy++) begin
          for (int dx = -1; dx <= 1; dx++) begin
            int px, py, k;
            px = x + dx;
            py = y + dy;
            k  = 3 * (dy + 1) + (dx + 1);
            if (px >= 1 && px <= w && py >= 1 && py <= h) e.data[k*DW +: DW] = mem[py][px];
          end
        end
        e.x = x;
        e.y = y;
        e.last = (x == w) && (y == h);
        q.push_back(e);
      end
    end
  endfunction

  task automatic fill_random();
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++) mem[y][x] = DW'($urandom);
  endtask

  task automatic fill_const(input logic [DW-1:0] v);
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++) mem[y][x] = v;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_win_valid"}, win_valid, 0);
    check({tag, "_win_last"}, win_last, 0);
    check({tag, "_win_data"}, win_data, 0);
    check({tag, "_win_x"}, win_x, 0);
    check({tag, "_win_y"}, win_y, 0);
    check({tag, "_mem_cell_x"}, mem_cell_x, 0);
    check({tag, "_mem_cell_y"}, mem_cell_y, 0);
    check({tag, "_mem_we"}, mem_we, 0);
  endtask

  // Issues start and checks the first window appears 11 cycles later.
  task automatic launch_frame(input int w, input int h);
    int lat;
    lat = 0;
    push_frame(w, h);
    @(posedge clk); #1;
    img_width = CW'(w); img_height = CW'(h); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (win_valid) begin
        lat = i;
        break;
      end
    end
    check("first_latency", lat, 11);
  endtask

  task automatic finish_frame(input int w, input int h);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60 * w * h + 100; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check("frame_done", seen, 1);
    check("queue_drained", q.size(), 0);
    @(negedge clk);
    check("idle_after_done", busy, 0);
  endtask

  task automatic run_frame(input int w, input int h);
    launch_frame(w, h);
    finish_frame(w, h);
  endtask

  // Consumer ready, changed just after each rising edge.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (ready_mode == 1)      win_ready = 1'b1;
      else if (ready_mode == 2) win_ready = 1'b0;
      else                      win_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: scoreboard pop on handshake, stall stability, window spacing, done after last.
  initial begin
    logic [9*DW-1:0] pd;
    logic [CW-1:0]   pxc, pyc, pax, pay;
    bit              pl, pv, phs, gap, done_due;
    int              hs_edge;
    win_t            e;
    pv = 0; phs = 0; gap = 0; done_due = 0; hs_edge = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 0; phs = 0; gap = 0; done_due = 0;
      end else begin
        if (done_due) begin
          check("done_after_last", done, 1);
          done_due = 0;
        end
        if (pv && !phs) begin
          check("stall_valid", win_valid, 1);
          check("stall_data", win_data, pd);
          check("stall_x", win_x, pxc);
          check("stall_y", win_y, pyc);
          check("stall_last", win_last, pl);
          check("stall_addr_x", mem_cell_x, pax);
          check("stall_addr_y", mem_cell_y, pay);
        end
        if (win_valid && !pv && gap) begin
          check("window_gap", cyc - hs_edge, 10);
          gap = 0;
        end
        phs = 0;
        if (win_valid && win_ready) begin
          phs = 1;
          if (q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_window: got window at (%0d,%0d), expected none", win_x, win_y);
          end else begin
            e = q.pop_front();
            check("win_data", win_data, e.data);
            check("win_x", win_x, e.x);
            check("win_y", win_y, e.y);
            check("win_last", win_last, e.last);
            if (e.last) begin
              done_due = 1;
            end else begin
              gap = 1;
              hs_edge = cyc + 1;
            end
          end
        end
        pv = win_valid; pd = win_data; pxc = win_x; pyc = win_y; pl = win_last;
        pax = mem_cell_x; pay = mem_cell_y;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit vf;
    int bad_w [3] = '{0, 513, 3};
    int bad_h [3] = '{4, 2, 0};
    rst = 1'b1; start = 1'b0; img_width = '0; img_height = '0; win_ready = 1'b0;
    fill_random();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");

    // start coinciding with reset is ignored
    @(posedge clk); #1;
    img_width = 10'd4; img_height = 10'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; rst = 1'b0;
    @(negedge clk);
    check("start_with_rst_busy", busy, 0);

    // single-pixel frame
    fill_const(8'hFF);
    mem[1][1] = 8'h55;
    run_frame(1, 1);

    // 3x3 ramp frame
    fill_const(8'hEE);
    for (int y = 1; y <= 3; y++)
      for (int x = 1; x <= 3; x++) mem[y][x] = DW'((y - 1) * 3 + x);
    run_frame(3, 3);

    // stalled consumer plus ignored start/size change while busy
    fill_random();
    ready_mode = 2;
    launch_frame(3, 2);
    @(posedge clk); #1;
    img_width = 10'd5; img_height = 10'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    ready_mode = 0;
    finish_frame(3, 2);

    // invalid sizes: straight to done, no windows
    for (int t = 0; t < 3; t++) begin
      @(posedge clk); #1;
      img_width = CW'(bad_w[t]); img_height = CW'(bad_h[t]); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check("bad_size_busy", busy, 1);
      check("bad_size_done", done, 1);
      @(negedge clk);
      check("bad_size_busy_after", busy, 0);
      check("bad_size_done_after", done, 0);
      vf = 1'b0;
      repeat (12) begin
        @(negedge clk);
        if (win_valid) vf = 1'b1;
      end
      check("bad_size_no_window", vf, 0);
    end

    // randomized frames
    repeat (6) begin
      fill_random();
      run_frame($urandom_range(1, 6), $urandom_range(1, 6));
    end

    // reset while fetching pixel (2,1), then a clean restart
    fill_const(8'hEE);
    for (int y = 1; y <= 3; y++)
      for (int x = 1; x <= 3; x++) mem[y][x] = DW'((y - 1) * 3 + x);
    ready_mode = 1;
    launch_frame(3, 3);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("fetch_centre_x_before_rst", win_x, 2);
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("midframe_rst");
    ready_mode = 0;
    run_frame(3, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
